// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a show-ahead receive FIFO.
//
// The rx line goes through a two-flop synchroniser. An oversampling tick
// runs only while a frame is in progress. Each frame is sampled at bit
// centres: the start bit is checked at tick OVERSAMPLE/2, and every later
// sample is taken OVERSAMPLE ticks after the previous one. The received
// {frame_err, parity_err, data} entry is pushed into a small FIFO in the
// same cycle as the last stop sample.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   rd_en      in   pop the head entry (ignored while data_valid = 0)
//   data_valid out  FIFO non-empty; head entry shown on data/flags
//   data       out  head entry data, LSB = first bit received
//   parity_err out  head entry parity mismatch
//   frame_err  out  head entry had a stop bit sampled low
//   overflow   out  one-cycle pulse: a completed frame was dropped (FIFO full)
//   busy       out  receiver is inside a frame (FSM not IDLE)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | confirming the start bit at its centre
// DATA      | shifting in DATA_BITS data bits, LSB first
// PARITY    | sampling and checking the parity bit
// STOP      | sampling STOP_BITS stop bits, push on the last one
// WAIT_IDLE | last stop bit was low (break/noise), wait for rx_s high

module uart_rx_param #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic                 data_valid,
   output logic [DATA_BITS-1:0] data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overflow,
   output logic                 busy
);

   localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BC_W  = $clog2(DATA_BITS);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = DATA_BITS + 2;
   localparam bit PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_e;

   // synchroniser plus one extra stage for edge detection
   logic rx_meta_q, rx_s_q, rx_prev_q;

   state_e                 state_q, state_d;
   logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
   logic [OS_W-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;

   logic                   rx_fall, tick, sample;
   logic                   push;
   logic [EW-1:0]          push_entry;

   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_q, rd_ptr_q;
   logic                   overflow_q;
   logic                   fifo_empty, fifo_full, pop, push_ok;
   logic [EW-1:0]          head;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_s_q;
   assign busy    = (state_q != S_IDLE);
   // div_cnt_q counts down to 0 once per tick; tick_cnt_q counts ticks
   // down to the next bit centre.
   assign tick    = busy && (div_cnt_q == '0);
   assign sample  = tick && (tick_cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      push       = 1'b0;

      if (busy) begin
         div_cnt_d = tick ? DIV_W'(DIV - 1) : div_cnt_q - 1'b1;
         if (tick) begin
            tick_cnt_d = (tick_cnt_q == '0) ? OS_W'(OVERSAMPLE - 1)
                                            : tick_cnt_q - 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d    = S_START;
               div_cnt_d  = DIV_W'(DIV - 1);
               tick_cnt_d = OS_W'(OVERSAMPLE / 2 - 1);
               bit_cnt_d  = '0;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
            end
         end
         S_START: begin
            if (sample) begin
               state_d   = rx_s_q ? S_IDLE : S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (sample) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (sample) begin
               perr_d  = rx_s_q ^ (^shift_q) ^ PAR_ODD;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (sample) begin
               ferr_d = ferr_q | ~rx_s_q;
               if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign push_entry = {ferr_d, perr_q, shift_q};

   // Extra pointer bit separates full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = rd_en && !fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok    = push && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         overflow_q <= push && fifo_full && !pop;
      end
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign data_valid = !fifo_empty;
   assign data       = data_valid ? head[DATA_BITS-1:0] : '0;
   assign parity_err = data_valid & head[DATA_BITS];
   assign frame_err  = data_valid & head[DATA_BITS+1];
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

   localparam int CLK_FREQ = 100_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int OS       = 10;
   localparam int DIV      = CLK_FREQ / (BAUD * OS);
   localparam int BIT_CYC  = DIV * OS;
   // Cycles from driving the start edge to the 8N1 push edge: 3 register
   // stages of input delay, half a bit to the start centre, then 9 bits.
   localparam int PUSH_OFF0 = 3 + DIV * (OS / 2) + BIT_CYC * 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rx0, rx1, rd0, rd1;
   logic       dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;
   logic [7:0] d0, d1;

   // DUT0: 8N1.  DUT1: 8 data, even parity, 2 stop bits.
   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                   .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
   u_dut0 (.clk(clk), .rst(rst), .rx(rx0), .rd_en(rd0), .data_valid(dv0),
           .data(d0), .parity_err(pe0), .frame_err(fe0), .overflow(ov0),
           .busy(busy0));

   uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                   .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
   u_dut1 (.clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .data_valid(dv1),
           .data(d1), .parity_err(pe1), .frame_err(fe1), .overflow(ov1),
           .busy(busy1));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;
   int ovf0 = 0, ovf1 = 0;
   int frame_start = -1;
   logic [9:0] q0[$], q1[$];
   logic [9:0] e0, e1;
   logic dv0_prev = 1'b0, dv1_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
   endtask

   // Monitors: pop the scoreboard whenever a DUT entry is consumed.
   always @(negedge clk) begin
      if (rst) dv0_prev = 1'b0;
      else begin
         if (ov0) ovf0++;
         if (dv0 && rd0) begin
            if (q0.size() == 0) chk_fail("pop0_unexpected");
            else begin
               e0 = q0.pop_front();
               chk("pop0_entry", {fe0, pe0, d0}, e0);
            end
         end
         if (!dv0 && dv0_prev) chk("empty0_outputs_zero", {fe0, pe0, d0}, 0);
         dv0_prev = dv0;
      end
   end

   always @(negedge clk) begin
      if (rst) dv1_prev = 1'b0;
      else begin
         if (ov1) ovf1++;
         if (dv1 && rd1) begin
            if (q1.size() == 0) chk_fail("pop1_unexpected");
            else begin
               e1 = q1.pop_front();
               chk("pop1_entry", {fe1, pe1, d1}, e1);
            end
         end
         if (!dv1 && dv1_prev) chk("empty1_outputs_zero", {fe1, pe1, d1}, 0);
         dv1_prev = dv1;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int w, input logic v);
      if (w == 0) rx0 = v;
      else rx1 = v;
   endtask

   task automatic bit_out(input int w, input logic v);
      set_rx(w, v);
      idle(BIT_CYC);
   endtask

   // Sends one frame; the reference entry follows the framing rules:
   // even parity expects the XOR of the data bits, any low stop is an error.
   task automatic send(input int w, input logic [7:0] d, input logic pbit,
                       input logic s0, input logic s1, input bit expect_push);
      logic [9:0] e;
      if (expect_push) begin
         e[7:0] = d;
         e[8]   = (w == 1) && (pbit != (^d));
         e[9]   = (w == 1) ? !(s0 && s1) : !s0;
         if (w == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      @(posedge clk);
      #1;
      frame_start = cyc;
      bit_out(w, 1'b0);
      for (int i = 0; i < 8; i++) bit_out(w, d[i]);
      if (w == 1) bit_out(w, pbit);
      bit_out(w, s0);
      if (w == 1) bit_out(w, s1);
   endtask

   task automatic pop(input int w);
      int k;
      k = 0;
      while (((w == 0) ? !dv0 : !dv1) && k < 3000) begin
         idle(1);
         k++;
      end
      if (k >= 3000) chk_fail("pop_wait_valid");
      @(posedge clk);
      #1;
      if (w == 0) rd0 = 1'b1; else rd1 = 1'b1;
      @(posedge clk);
      #1;
      rd0 = 1'b0;
      rd1 = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       p, s0, s1;
      int         k;

      rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0;
      idle(5);
      chk("reset_outputs0", {dv0, fe0, pe0, d0, ov0, busy0}, 0);
      chk("reset_outputs1", {dv1, fe1, pe1, d1, ov1, busy1}, 0);
      rst = 1'b0;
      idle(20);

      // "T", ":", "1" without reading, with push-to-valid latency on "T"
      frame_start = -1;
      fork
         send(0, 8'h54, 1'b0, 1'b1, 1'b1, 1'b1);
         begin
            int kk;
            kk = 0;
            while (!(frame_start >= 0 && cyc == frame_start + PUSH_OFF0 - 1) && kk < 3000) begin
               @(negedge clk);
               kk++;
            end
            if (kk >= 3000) chk_fail("latency_wait");
            chk("valid_before_push", dv0, 0);
            @(negedge clk);
            chk("valid_after_push", dv0, 1);
         end
      join
      idle(50);
      send(0, 8'h3A, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(50);
      send(0, 8'h31, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(20);
      chk("ascii_head_valid", dv0, 1);
      chk("ascii_head_data", d0, 8'h54);
      pop(0); pop(0); pop(0);
      idle(2);
      chk("ascii_drained", {dv0, fe0, pe0, d0}, 0);

      // rd_en while empty
      rd0 = 1'b1;
      idle(3);
      rd0 = 1'b0;
      idle(1);
      chk("rd_empty_valid", dv0, 0);

      // 300 ns glitch: false start
      @(posedge clk);
      #1;
      rx0 = 1'b0;
      idle(20);
      chk("glitch_busy_rises", busy0, 1);
      idle(10);
      rx0 = 1'b1;
      idle(70);
      chk("glitch_busy_back", busy0, 0);
      idle(200);
      chk("glitch_no_entry", {dv0, fe0, pe0}, 0);

      // break: stop bit low then line held low
      send(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(250);
      chk("break_busy_held", busy0, 1);
      idle(250);
      rx0 = 1'b1;
      idle(10);
      chk("break_busy_released", busy0, 0);
      chk("break_entry_valid", dv0, 1);
      pop(0);
      idle(2);
      chk("break_single_entry", dv0, 0);
      idle(50);
      send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      pop(0);

      // overflow on 5th push
      idle(50);
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i);
         send(0, b, 1'b0, 1'b1, 1'b1, i < 5);
         idle(20);
      end
      chk("overflow_once", ovf0, 1);
      chk("overflow_head", d0, 8'h01);
      pop(0); pop(0); pop(0); pop(0);
      idle(2);
      chk("overflow_drained", dv0, 0);

      // same, with a pop in the 5th push cycle
      for (int i = 1; i <= 4; i++) begin
         b = 8'(i);
         send(0, b, 1'b0, 1'b1, 1'b1, 1'b1);
         idle(20);
      end
      frame_start = -1;
      fork
         send(0, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
         begin
            int kk;
            kk = 0;
            while (!(frame_start >= 0 && cyc == frame_start + PUSH_OFF0 - 1) && kk < 3000) begin
               idle(1);
               kk++;
            end
            if (kk >= 3000) chk_fail("push_pop_wait");
            rd0 = 1'b1;
            idle(1);
            rd0 = 1'b0;
         end
      join
      idle(20);
      chk("push_pop_no_overflow", ovf0, 1);
      pop(0); pop(0); pop(0); pop(0);
      idle(2);
      chk("push_pop_drained", dv0, 0);

      // 8E2: parity and stop-bit handling
      send(1, 8'h31, 1'b1, 1'b1, 1'b1, 1'b1);
      pop(1);
      send(1, 8'h31, 1'b0, 1'b1, 1'b1, 1'b1);
      pop(1);
      b = 8'h4B;
      send(1, b, ^b, 1'b0, 1'b1, 1'b1);
      pop(1);
      b = 8'hC3;
      send(1, b, ^b, 1'b1, 1'b0, 1'b1);
      idle(20);
      chk("stop2_low_busy", busy1, 1);
      rx1 = 1'b1;
      pop(1);

      // randomized traffic, reader always ready
      rd0 = 1'b1;
      rd1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom);
         s0 = ($urandom_range(0, 4) != 0);
         send(0, b, 1'b0, s0, 1'b1, 1'b1);
         rx0 = 1'b1;
         idle($urandom_range(20, 150));
      end
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom);
         p  = (^b) ^ ($urandom_range(0, 2) == 0);
         s0 = ($urandom_range(0, 4) != 0);
         s1 = ($urandom_range(0, 4) != 0);
         send(1, b, p, s0, s1, 1'b1);
         rx1 = 1'b1;
         idle($urandom_range(20, 150));
      end
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 2000) begin
         idle(1);
         k++;
      end
      chk("random_q0_drained", q0.size(), 0);
      chk("random_q1_drained", q1.size(), 0);
      rd0 = 1'b0;
      rd1 = 1'b0;
      idle(5);

      // reset mid-frame with an entry already stored
      send(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(50);
      chk("pre_reset_valid", dv0, 1);
      b = 8'h7E;
      @(posedge clk);
      #1;
      bit_out(0, 1'b0);
      for (int i = 0; i < 3; i++) bit_out(0, b[i]);
      rx0 = b[3];
      idle(50);
      rst = 1'b1;
      rx0 = 1'b1;
      q0.delete();
      q1.delete();
      idle(1);
      chk("mid_reset_outputs", {dv0, fe0, pe0, d0, ov0, busy0}, 0);
      rst = 1'b0;
      idle(300);
      chk("post_reset_quiet", {dv0, busy0}, 0);
      send(0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b1);
      pop(0);
      idle(5);
      chk("post_reset_drained", dv0, 0);

      chk("total_overflow0", ovf0, 1);
      chk("total_overflow1", ovf1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
